serial_frame_arbiter: RTL and testbench

Round-robin controller that shares one WIDTH-bit parallel-in/serial-out shift register between two requesters. Each requester offers a parallel word with a req/gnt handshake. The block grants one requester, loads the word into the shift register, and shifts it out MSB-first on a single serial line with a frame-valid strobe. A programmable idle gap follows each frame. It sits between the requesting blocks and the serial output pin.

---
 rtl/serial_frame_arbiter.sv | 120 ++++++++++++
 tb/tb_serial_frame_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_arbiter.sv
// Two-requester round-robin arbiter feeding one PISO shift register, MSB-first with a post-frame gap.
// Grant is combinational in IDLE (zero-cycle accept, first bit next cycle); requests wait while busy.
module serial_frame_arbiter #(
  parameter int WIDTH = 4,
  parameter int GAP   = 1
) (
  input  logic             clk_i,
  input  logic             clr_n_i,
  input  logic             req0_i,
  input  logic [WIDTH-1:0] data0_i,
  input  logic             req1_i,
  input  logic [WIDTH-1:0] data1_i,
  output logic             gnt0_o,
  output logic             gnt1_o,
  output logic             so_o,
  output logic             sv_o,
  output logic             done_o,
  output logic             busy_o
);

  localparam int BW = $clog2(WIDTH);
  localparam int GW = ($clog2(GAP + 1) > 1) ? $clog2(GAP + 1) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [BW-1:0]    bitcnt_q, bitcnt_d;
  logic [GW-1:0]    gapcnt_q, gapcnt_d;

  logic gnt0, gnt1, so, sv, done, busy;

  always_ff @(posedge clk_i or negedge clr_n_i) begin
    if (!clr_n_i) begin
      state_q  <= S_IDLE;
      ptr_q    <= 1'b0;
      sreg_q   <= '0;
      bitcnt_q <= '0;
      gapcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      sreg_q   <= sreg_d;
      bitcnt_q <= bitcnt_d;
      gapcnt_q <= gapcnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    sreg_d   = sreg_q;
    bitcnt_d = bitcnt_q;
    gapcnt_d = gapcnt_q;
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    so       = 1'b0;
    sv       = 1'b0;
    done     = 1'b0;
    busy     = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Gating with clr_n keeps grants quiet while reset is held.
        if (clr_n_i) begin
          gnt0 = req0_i & (~req1_i | ~ptr_q);
          gnt1 = req1_i & (~req0_i |  ptr_q);
        end
        if (gnt0 || gnt1) begin
          sreg_d   = gnt0 ? data0_i : data1_i;
          bitcnt_d = '0;
          ptr_d    = gnt0;
          state_d  = S_SHIFT;
        end
      end

      S_SHIFT: begin
        so     = sreg_q[WIDTH-1];
        sv     = 1'b1;
        busy   = 1'b1;
        sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
        if (bitcnt_q == BIT_LAST) begin
          done     = 1'b1;
          gapcnt_d = '0;
          state_d  = (GAP > 0) ? S_GAP : S_IDLE;
        end else begin
          bitcnt_d = bitcnt_q + 1'b1;
        end
      end

      S_GAP: begin
        busy = 1'b1;
        if (gapcnt_q == GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          gapcnt_d = gapcnt_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign gnt0_o = gnt0;
  assign gnt1_o = gnt1;
  assign so_o   = so;
  assign sv_o   = sv;
  assign done_o = done;
  assign busy_o = busy;

endmodule

// File: tb/tb_serial_frame_arbiter.sv
// Directed bench: instance a uses WIDTH=4/GAP=1, instance b uses WIDTH=8/GAP=0.
// Output vectors are packed as {gnt0, gnt1, so, sv, done, busy}.
module tb_serial_frame_arbiter;

  logic clk;
  logic clr_n;

  logic       a_req0, a_req1;
  logic [3:0] a_d0, a_d1;
  logic       a_gnt0, a_gnt1, a_so, a_sv, a_done, a_busy;

  logic       b_req0, b_req1;
  logic [7:0] b_d0, b_d1;
  logic       b_gnt0, b_gnt1, b_so, b_sv, b_done, b_busy;

  logic [5:0] oa, ob;
  assign oa = {a_gnt0, a_gnt1, a_so, a_sv, a_done, a_busy};
  assign ob = {b_gnt0, b_gnt1, b_so, b_sv, b_done, b_busy};

  int vecs = 0;
  int errs = 0;

  serial_frame_arbiter #(.WIDTH(4), .GAP(1)) dut_a (
    .clk_i   (clk),
    .clr_n_i (clr_n),
    .req0_i  (a_req0),
    .data0_i (a_d0),
    .req1_i  (a_req1),
    .data1_i (a_d1),
    .gnt0_o  (a_gnt0),
    .gnt1_o  (a_gnt1),
    .so_o    (a_so),
    .sv_o    (a_sv),
    .done_o  (a_done),
    .busy_o  (a_busy)
  );

  serial_frame_arbiter #(.WIDTH(8), .GAP(0)) dut_b (
    .clk_i   (clk),
    .clr_n_i (clr_n),
    .req0_i  (b_req0),
    .data0_i (b_d0),
    .req1_i  (b_req1),
    .data1_i (b_d1),
    .gnt0_o  (b_gnt0),
    .gnt1_o  (b_gnt1),
    .so_o    (b_so),
    .sv_o    (b_sv),
    .done_o  (b_done),
    .busy_o  (b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr_n  = 1'b0;
    a_req0 = 1'b0; a_req1 = 1'b0; a_d0 = '0; a_d1 = '0;
    b_req0 = 1'b0; b_req1 = 1'b0; b_d0 = '0; b_d1 = '0;
    repeat (2) @(posedge clk);
    #1;
    clr_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    clr_n  = 1'b0;
    a_req0 = 1'b1; a_req1 = 1'b1; b_req0 = 1'b1;
    #2;
    vecs++; if (oa !== 6'b000000) begin errs++; $display("FAIL reset_hold_a got %b want %b", oa, 6'b000000); end
    vecs++; if (ob !== 6'b000000) begin errs++; $display("FAIL reset_hold_b got %b want %b", ob, 6'b000000); end
    tick();
    clr_n = 1'b1; a_d0 = 4'hF;
    #2;
    vecs++; if (oa !== 6'b100000) begin errs++; $display("FAIL reset_first_grant got %b want %b", oa, 6'b100000); end
    tick();
    a_req0 = 1'b0; b_req0 = 1'b0;
    #2;
    vecs++; if (oa !== 6'b001101) begin errs++; $display("FAIL reset_shift_bit0 got %b want %b", oa, 6'b001101); end
    tick();
    #2;
    vecs++; if (oa !== 6'b001101) begin errs++; $display("FAIL reset_shift_bit1 got %b want %b", oa, 6'b001101); end
    clr_n = 1'b0;
    #1;
    vecs++; if (oa !== 6'b000000) begin errs++; $display("FAIL reset_async_clear got %b want %b", oa, 6'b000000); end
    for (int k = 0; k < 3; k++) begin
      tick();
      #2;
      vecs++; if (oa !== 6'b000000) begin errs++; $display("FAIL reset_no_done cyc%0d got %b want %b", k, oa, 6'b000000); end
    end
    tick();
    clr_n = 1'b1; a_req0 = 1'b1;
    #2;
    vecs++; if (oa !== 6'b100000) begin errs++; $display("FAIL reset_ptr_zero got %b want %b", oa, 6'b100000); end
    tick();
    a_req0 = 1'b0; a_req1 = 1'b0;
    #2;
    vecs++; if (oa !== 6'b001101) begin errs++; $display("FAIL reset_refill got %b want %b", oa, 6'b001101); end
  endtask

  task automatic test_single_frame();
    logic [5:0] exp [7];
    exp = '{6'b100000, 6'b001101, 6'b000101, 6'b001101,
            6'b001111, 6'b000001, 6'b000000};
    do_reset();
    a_req0 = 1'b1; a_d0 = 4'b1011;
    for (int k = 0; k < 7; k++) begin
      if (k == 1) a_req0 = 1'b0;
      #2;
      vecs++; if (oa !== exp[k]) begin errs++; $display("FAIL single_frame cyc%0d got %b want %b", k, oa, exp[k]); end
      tick();
    end
  endtask

  task automatic test_contention();
    logic [5:0] exp [13];
    exp = '{6'b100000, 6'b001101, 6'b000101, 6'b001101, 6'b000111,
            6'b000001, 6'b010000, 6'b000101, 6'b001101, 6'b000101,
            6'b001111, 6'b000001, 6'b100000};
    do_reset();
    a_req0 = 1'b1; a_req1 = 1'b1; a_d0 = 4'hA; a_d1 = 4'h5;
    for (int k = 0; k < 13; k++) begin
      if (k == 1) a_req0 = 1'b0;
      if (k == 7) a_req1 = 1'b0;
      if (k == 12) begin a_req0 = 1'b1; a_req1 = 1'b1; end
      #2;
      vecs++; if (oa !== exp[k]) begin errs++; $display("FAIL contention cyc%0d got %b want %b", k, oa, exp[k]); end
      tick();
    end
    a_req0 = 1'b0; a_req1 = 1'b0;
  endtask

  task automatic test_req_while_busy();
    logic [5:0] exp [8];
    exp = '{6'b100000, 6'b001101, 6'b000101, 6'b001101,
            6'b001111, 6'b000001, 6'b010000, 6'b000101};
    do_reset();
    a_req0 = 1'b1; a_d0 = 4'b1011; a_d1 = 4'b0110;
    for (int k = 0; k < 8; k++) begin
      if (k == 1) begin a_req0 = 1'b0; a_req1 = 1'b1; end
      if (k == 7) a_req1 = 1'b0;
      #2;
      vecs++; if (oa !== exp[k]) begin errs++; $display("FAIL req_while_busy cyc%0d got %b want %b", k, oa, exp[k]); end
      tick();
    end
  endtask

  task automatic test_withdrawn_req();
    logic [5:0] exp [8];
    exp = '{6'b100000, 6'b001101, 6'b000101, 6'b001101,
            6'b001111, 6'b000001, 6'b000000, 6'b010000};
    do_reset();
    a_req0 = 1'b1; a_d0 = 4'b1011; a_d1 = 4'hF;
    for (int k = 0; k < 8; k++) begin
      if (k == 1) begin a_req0 = 1'b0; a_req1 = 1'b1; end
      if (k == 2) a_req1 = 1'b0;
      if (k == 7) begin a_req0 = 1'b1; a_req1 = 1'b1; end
      #2;
      vecs++; if (oa !== exp[k]) begin errs++; $display("FAIL withdrawn_req cyc%0d got %b want %b", k, oa, exp[k]); end
      tick();
    end
    a_req0 = 1'b0; a_req1 = 1'b0;
  endtask

  task automatic test_back_to_back_gap0();
    logic [7:0] w [3];
    logic [5:0] e;
    w = '{8'hC3, 8'h5A, 8'h96};
    do_reset();
    b_req0 = 1'b1; b_d0 = w[0];
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 9; k++) begin
        if (k == 1 && f < 2) b_d0 = w[f+1];
        if (k == 0) e = 6'b100000;
        else        e = {2'b00, w[f][8-k], 1'b1, (k == 8), 1'b1};
        #2;
        vecs++; if (ob !== e) begin errs++; $display("FAIL gap0_stream f%0d cyc%0d got %b want %b", f, k, ob, e); end
        tick();
      end
    end
    b_req0 = 1'b0;
    #2;
    vecs++; if (ob !== 6'b000000) begin errs++; $display("FAIL gap0_idle got %b want %b", ob, 6'b000000); end
  endtask

  initial begin
    clr_n  = 1'b0;
    a_req0 = 1'b0; a_req1 = 1'b0; a_d0 = '0; a_d1 = '0;
    b_req0 = 1'b0; b_req1 = 1'b0; b_d0 = '0; b_d1 = '0;
    test_reset();
    test_single_frame();
    test_contention();
    test_req_while_busy();
    test_withdrawn_req();
    test_back_to_back_gap0();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
